// File: rtl/b_lut_pkg.sv
// Shared definitions for the nibble LUT sequencer:
// FSM state encoding, nibble width, LUT depth and word geometry.
package b_lut_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W     = 4;
    localparam int LUT_DEPTH = 16;
    localparam int NIBBLES   = 8;
    localparam int LUT_W     = NIB_W * LUT_DEPTH;

endpackage

// File: rtl/b_lut_nibble.sv
// Single-lane nibble lookup: idx selects one 4-bit entry of lut.
// Ports: idx (4b index), lut (64b table, entry i at [4i+3:4i]), value (4b).
module b_lut_nibble
    import b_lut_pkg::*;
(
    input  logic [NIB_W-1:0] idx,
    input  logic [LUT_W-1:0] lut,
    output logic [NIB_W-1:0] value
);

    assign value = lut[{idx, 2'b00} +: NIB_W];

endmodule

// File: rtl/b_lut_seq.sv
// Sequential 32-bit nibble LUT: LANES nibbles translated per BUSY cycle.
// Ports: clock, reset, flush, valid/ready, crs1-3, result/result_valid/result_ready.
module b_lut_seq
    import b_lut_pkg::*;
#(
    parameter int LANES = 2
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] crs1,
    input  logic [31:0] crs2,
    input  logic [31:0] crs3,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ready
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("b_lut_seq: LANES must be 1, 2, 4 or 8");
    end

    localparam int         GROUPS = NIBBLES / LANES;
    localparam logic [2:0] LAST   = 3'(GROUPS - 1);

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic              load, wr;
    logic [31:0]       crs1_q, crs2_q, crs3_q, result_q;
    logic [2:0]        nib [LANES];
    logic [NIB_W-1:0]  idx [LANES];
    logic [NIB_W-1:0]  val [LANES];

    // Nibble position handled by each lane in the current group.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            nib[l] = 3'(int'(cnt) * LANES + l);
            idx[l] = crs1_q[{nib[l], 2'b00} +: NIB_W];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        b_lut_nibble u_nib (
            .idx   (idx[l]),
            .lut   ({crs3_q, crs2_q}),
            .value (val[l])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        wr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid) begin
                    load    = 1'b1;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                wr = 1'b1;
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            DONE: begin
                if (result_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Flush aborts whatever is in flight; result keeps its value.
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            load    = 1'b0;
            wr      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            crs1_q   <= '0;
            crs2_q   <= '0;
            crs3_q   <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                crs1_q <= crs1;
                crs2_q <= crs2;
                crs3_q <= crs3;
            end
            if (wr) begin
                for (int l = 0; l < LANES; l++) begin
                    result_q[{nib[l], 2'b00} +: NIB_W] <= val[l];
                end
            end
        end
    end

    assign ready        = (state == IDLE);
    assign result_valid = (state == DONE);
    assign result       = result_q;

endmodule

// File: tb/tb_b_lut_seq.sv
// Scoreboard bench for b_lut_seq with LANES = 2, 8 and 1 instances.
// Stimulus pushes expected results; a monitor checks data and latency.
module tb_b_lut_seq;

    localparam int LT [3] = '{2, 8, 1};

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] crs1 = '0, crs2 = '0, crs3 = '0;
    logic        vld [3];
    logic        rdy [3];
    logic        rv  [3];
    logic        rr  [3];
    logic [31:0] res [3];

    exp_t sbq [3][$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        b_lut_seq #(.LANES(LT[g])) u_dut (
            .clock        (clock),
            .reset        (reset),
            .flush        (flush),
            .valid        (vld[g]),
            .ready        (rdy[g]),
            .crs1         (crs1),
            .crs2         (crs2),
            .crs3         (crs3),
            .result       (res[g]),
            .result_valid (rv[g]),
            .result_ready (rr[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_lut(input logic [31:0] c1,
                                            input logic [31:0] c2,
                                            input logic [31:0] c3);
        logic [63:0] lut;
        logic [63:0] ent;
        logic [31:0] r;
        lut = {c3, c2};
        r   = '0;
        for (int i = 0; i < 8; i++) begin
            ent = lut >> (int'(c1[4*i +: 4]) * 4);
            r[4*i +: 4] = ent[3:0];
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int g, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] c3,
                         input logic [31:0] exp);
        exp_t e;
        int n;
        n = 0;
        while (!rdy[g] && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("issue_ready_timeout", 32'(rdy[g]), 32'd1);
        crs1 = c1;
        crs2 = c2;
        crs3 = c3;
        vld[g] = 1'b1;
        e.data = exp;
        e.acc  = cyc + 1;
        sbq[g].push_back(e);
        @(negedge clock);
        vld[g] = 1'b0;
    endtask

    task automatic wait_rv(input int g);
        int n;
        n = 0;
        while (!rv[g] && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk("wait_result_valid_timeout", 32'(rv[g]), 32'd1);
    endtask

    // Monitor: on each rising result_valid, pop and compare data and latency.
    logic rv_prev [3];
    initial begin
        for (int g = 0; g < 3; g++) rv_prev[g] = 1'b0;
        forever begin
            @(negedge clock);
            for (int g = 0; g < 3; g++) begin
                if (rv[g] && !rv_prev[g]) begin
                    if (sbq[g].size() == 0) begin
                        chk($sformatf("unexpected_result_l%0d", LT[g]), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sbq[g].pop_front();
                        chk($sformatf("result_l%0d", LT[g]), res[g], e.data);
                        chk($sformatf("latency_l%0d", LT[g]),
                            32'(cyc - e.acc), 32'(8 / LT[g]));
                    end
                end
                rv_prev[g] = rv[g];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, c, e;
        for (int g = 0; g < 3; g++) begin
            vld[g] = 1'b0;
            rr[g]  = 1'b1;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int g = 0; g < 3; g++) begin
            chk("reset_ready", 32'(rdy[g]), 32'd1);
            chk("reset_result_valid", 32'(rv[g]), 32'd0);
            chk("reset_result", res[g], 32'h0);
        end

        // Identity table
        issue(0, 32'h12345678, 32'h76543210, 32'hFEDCBA98, 32'h12345678);
        wait_rv(0);
        @(negedge clock);
        chk("identity_back_to_idle", 32'(rdy[0]), 32'd1);

        // Inverse table
        issue(0, 32'h0000F00F, 32'h89ABCDEF, 32'h01234567, 32'hFFFF0FF0);
        wait_rv(0);
        @(negedge clock);

        // Backpressure in DONE
        rr[0] = 1'b0;
        issue(0, 32'hA5C30F96, 32'h76543210, 32'hFEDCBA98, 32'hA5C30F96);
        wait_rv(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_result_valid", 32'(rv[0]), 32'd1);
            chk("bp_result", res[0], 32'hA5C30F96);
            chk("bp_ready", 32'(rdy[0]), 32'd0);
        end
        rr[0] = 1'b1;
        @(negedge clock);
        chk("bp_release_ready", 32'(rdy[0]), 32'd1);
        chk("bp_release_valid", 32'(rv[0]), 32'd0);

        // Flush on the 2nd BUSY cycle
        issue(0, 32'h11111111, 32'h76543210, 32'hFEDCBA98, 32'h11111111);
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        sbq[0].delete();
        chk("flush_ready", 32'(rdy[0]), 32'd1);
        chk("flush_result_valid", 32'(rv[0]), 32'd0);
        issue(0, 32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567, 32'h21524110);
        wait_rv(0);
        @(negedge clock);

        // Reset while in DONE
        rr[0] = 1'b0;
        issue(0, 32'hCAFE0123, 32'h76543210, 32'hFEDCBA98, 32'hCAFE0123);
        wait_rv(0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rr[0] = 1'b1;
        chk("rst_done_result", res[0], 32'h0);
        chk("rst_done_result_valid", 32'(rv[0]), 32'd0);
        chk("rst_done_ready", 32'(rdy[0]), 32'd1);
        @(negedge clock);

        // Throughput: LANES=8 then LANES=1, random operands
        for (int g = 1; g < 3; g++) begin
            for (int k = 0; k < 6; k++) begin
                a = $urandom;
                b = $urandom;
                c = $urandom;
                e = ref_lut(a, b, c);
                issue(g, a, b, c, e);
            end
        end

        begin
            int n;
            n = 0;
            while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 40) begin
                @(negedge clock);
                n++;
            end
        end
        repeat (3) @(negedge clock);
        for (int g = 0; g < 3; g++)
            chk("scoreboard_drained", 32'(sbq[g].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/b_lut_seq.md
B_LUT_SEQ -- requirements
Module: b_lut_seq

Interface
REQ-001 The block SHALL have parameter LANES, default 2: nibble lookups per cycle; legal values 1, 2, 4, 8.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port flush, input, 1 bit: abort the current operation.
REQ-005 The block SHALL have port valid, input, 1 bit: request valid.
REQ-006 The block SHALL have port ready, output, 1 bit: request accepted when valid && ready.
REQ-007 The block SHALL have port crs1, input, 32 bits: LUT input, eight nibble indices.
REQ-008 The block SHALL have port crs2, input, 32 bits: LUT entries 0-7, entry i at bits [4i+3:4i].
REQ-009 The block SHALL have port crs3, input, 32 bits: LUT entries 8-15.
REQ-010 The block SHALL have port result, output, 32 bits: lookup result.
REQ-011 The block SHALL have port result_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port result_ready, input, 1 bit: consumer accepts result when result_valid && result_ready.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE, with a 3-bit group counter cnt.
REQ-014 In IDLE: ready=1 and result_valid=0; on valid && ready, latch crs1/crs2/crs3, set cnt=0, go to BUSY.
REQ-015 ready SHALL be 0 in BUSY and DONE; valid is ignored there, with no queueing.
REQ-016 In BUSY, each edge SHALL write result nibbles j = cnt*LANES .. cnt*LANES+LANES-1 with lut[crs1_q nibble j].
REQ-017 Each BUSY edge SHALL increment cnt; the 16 LUT entries are the concatenation {crs3_q, crs2_q}.
REQ-018 When cnt == 8/LANES-1 at an edge, that edge SHALL write the final group and move to DONE.
REQ-019 BUSY SHALL last exactly 8/LANES cycles; result_valid SHALL be observed high 8/LANES edges after the accepting edge.
REQ-020 In DONE, result_valid=1 and result SHALL hold stable until result_valid && result_ready; that edge returns to IDLE.
REQ-021 The earliest next acceptance SHALL be the edge after the return to IDLE, giving no same-cycle turnaround.
REQ-022 Result nibbles not yet written in BUSY SHALL retain their previous value; result is only meaningful in DONE.
REQ-023 flush=1 at any edge SHALL force IDLE and result_valid=0; flush overrides a simultaneous valid/ready or result handshake.
REQ-024 On flush, the result register SHALL keep its value, and cnt SHALL be cleared.
REQ-025 A LANES value outside {1,2,4,8} SHALL cause an elaboration error.

Reset
REQ-026 reset=1 at an edge SHALL set state to IDLE and clear cnt, result, result_valid and the operand registers to 0.
REQ-027 reset SHALL have priority over flush and all handshakes, including when asserted mid-BUSY or in DONE.
REQ-028 In the cycle after reset deasserts, ready SHALL be 1 and result_valid SHALL be 0.

Structure
REQ-029 State encodings, the nibble width (4) and the LUT depth (16) SHALL be placed in shared package b_lut_pkg.
REQ-030 Per-lane lookup SHALL be sub-module b_lut_nibble (4-bit index plus 64-bit table in, 4-bit value out), instantiated LANES times.
REQ-031 All state, counter, operand and result registers SHALL be clocked on clock only; there are no combinational paths from valid to result.

Verification
REQ-032 Identity test: with LANES=2, crs2=0x76543210, crs3=0xFEDCBA98, crs1=0x12345678 -> result_valid high 4 edges after accept, result=0x12345678.
REQ-033 Inverse test: crs2=0x89ABCDEF, crs3=0x01234567, crs1=0x0000F00F -> result=0xFFFF0FF0.
REQ-034 Backpressure test: hold result_ready=0 for 5 cycles in DONE -> result and result_valid stable, ready=0; raise result_ready -> IDLE next edge, ready=1.
REQ-035 Flush test: assert flush on the 2nd BUSY cycle -> next cycle ready=1, result_valid=0; a new request then completes correctly.
REQ-036 Reset test: assert reset in DONE -> result=0, result_valid=0, ready=1 after the edge.
REQ-037 Throughput test: with LANES=8 and LANES=1, random operands -> latency 1 and 8 edges respectively, and result matches the nibble-wise reference lookup on every operation.
